// File: rtl/staggered_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : staggered_adder_pkg
// Purpose  : Shared defaults and stage-count helper for the staggered adder.
// Revision : 1.0  initial release
// ============================================================================
package staggered_adder_pkg;

  localparam int N_DEF = 16;
  localparam int W_DEF = 4;

  function automatic int stages_of(input int n, input int w);
    return n / w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/staggered_adder_slice.sv
`default_nettype none
// ============================================================================
// Module   : staggered_adder_slice
// Purpose  : Registered W-bit adder with carry in/out; one pipeline stage.
// Revision : 1.0  initial release
// ============================================================================
module staggered_adder_slice
  import staggered_adder_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         Clock,
  input  logic         Reset_n,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W:0] w_total;

  assign w_total = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      sum  <= '0;
      cout <= 1'b0;
    end else begin
      sum  <= w_total[W-1:0];
      cout <= w_total[W];
    end
  end

endmodule
`default_nettype wire

// File: rtl/staggered_adder.sv
`default_nettype none
// ============================================================================
// Module   : staggered_adder
// Purpose  : Fully pipelined N-bit adder, one W-bit chunk per stage, with
//            input skew and output deskew so S/CO emerge aligned.
// Revision : 1.0  initial release
// ============================================================================
module staggered_adder
  import staggered_adder_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = W_DEF
) (
  input  logic         Clock,
  input  logic         Reset_n,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         CI,
  output logic [N-1:0] S,
  output logic         CO
);

  localparam int STAGES = stages_of(N, W);

  if ((N % W) != 0 || W < 1 || W > N) begin : g_bad_width
    $error("staggered_adder: N must be a positive multiple of W");
  end

  logic [N-1:0]    r_a;
  logic [N-1:0]    r_b;
  logic            r_ci;
  logic [STAGES:0] w_carry;

  // Stage 0: capture the full operand set every edge.
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      r_a  <= '0;
      r_b  <= '0;
      r_ci <= 1'b0;
    end else begin
      r_a  <= A;
      r_b  <= B;
      r_ci <= CI;
    end
  end

  assign w_carry[0] = r_ci;
  assign CO         = w_carry[STAGES];

  for (genvar j = 0; j < STAGES; j++) begin : g_chunk
    logic [W-1:0] w_a_in;
    logic [W-1:0] w_b_in;
    logic [W-1:0] w_sum;

    // Chunk j waits j cycles so it meets the carry rippling up from below.
    if (j == 0) begin : g_no_skew
      assign w_a_in = r_a[W-1:0];
      assign w_b_in = r_b[W-1:0];
    end else begin : g_skew
      logic [W-1:0] r_a_dly [j];
      logic [W-1:0] r_b_dly [j];

      always_ff @(posedge Clock) begin
        if (!Reset_n) begin
          for (int d = 0; d < j; d++) begin
            r_a_dly[d] <= '0;
            r_b_dly[d] <= '0;
          end
        end else begin
          r_a_dly[0] <= r_a[j*W +: W];
          r_b_dly[0] <= r_b[j*W +: W];
          for (int d = 1; d < j; d++) begin
            r_a_dly[d] <= r_a_dly[d-1];
            r_b_dly[d] <= r_b_dly[d-1];
          end
        end
      end

      assign w_a_in = r_a_dly[j-1];
      assign w_b_in = r_b_dly[j-1];
    end

    staggered_adder_slice #(
      .W (W)
    ) u_slice (
      .Clock   (Clock),
      .Reset_n (Reset_n),
      .a       (w_a_in),
      .b       (w_b_in),
      .cin     (w_carry[j]),
      .sum     (w_sum),
      .cout    (w_carry[j+1])
    );

    if (j == STAGES - 1) begin : g_no_deskew
      assign S[j*W +: W] = w_sum;
    end else begin : g_deskew
      logic [W-1:0] r_sum_dly [STAGES-1-j];

      always_ff @(posedge Clock) begin
        if (!Reset_n) begin
          for (int d = 0; d < STAGES - 1 - j; d++) begin
            r_sum_dly[d] <= '0;
          end
        end else begin
          r_sum_dly[0] <= w_sum;
          for (int d = 1; d < STAGES - 1 - j; d++) begin
            r_sum_dly[d] <= r_sum_dly[d-1];
          end
        end
      end

      assign S[j*W +: W] = r_sum_dly[STAGES-2-j];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_staggered_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_staggered_adder
// Purpose  : Directed self-checking bench for staggered_adder.
// Revision : 1.0  initial release
// ============================================================================
module tb_staggered_adder;
  import staggered_adder_pkg::*;

  localparam int N      = N_DEF;
  localparam int W      = W_DEF;
  localparam int STAGES = stages_of(N, W);
  localparam int L      = STAGES + 1;

  logic         Clock;
  logic         Reset_n;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         CI;
  logic [N-1:0] S;
  logic         CO;

  int n_tests;
  int n_fail;

  staggered_adder #(
    .N (N),
    .W (W)
  ) dut (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .A       (A),
    .B       (B),
    .CI      (CI),
    .S       (S),
    .CO      (CO)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Advance one rising edge; inputs are driven and outputs sampled 1 ns after.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge Clock);
      #1;
    end
  endtask

  task automatic drive(input logic [N-1:0] a, input logic [N-1:0] b, input logic ci);
    A  = a;
    B  = b;
    CI = ci;
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    drive(16'hFFFF, 16'hFFFF, 1'b1);
    tick(2);
    n_tests++;
    if ({CO, S} !== 17'h0_0000) begin
      n_fail++;
      $display("FAIL reset_state: got CO=%b S=%h, want CO=0 S=0000", CO, S);
    end
    Reset_n = 1'b1;
    drive('0, '0, 1'b0);
    tick(L);
    n_tests++;
    if ({CO, S} !== 17'h0_0000) begin
      n_fail++;
      $display("FAIL post_reset_idle: got CO=%b S=%h, want CO=0 S=0000", CO, S);
    end
  endtask

  task automatic test_low_range();
    logic [N:0] exp;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int c = 0; c < 2; c++) begin
          drive(N'(a), N'(b), c[0]);
          tick(L);
          exp = (N+1)'(a + b + c);
          n_tests++;
          if ({CO, S} !== exp) begin
            n_fail++;
            $display("FAIL low_range a=%0d b=%0d ci=%0d: got %0d, want %0d",
                     a, b, c, {CO, S}, exp);
          end
        end
      end
    end
  endtask

  task automatic test_ripple();
    drive('0, '0, 1'b0);
    tick(L);
    drive(16'hFFFF, 16'h0000, 1'b1);
    tick(L - 1);
    n_tests++;
    if ({CO, S} !== 17'h0_0000) begin
      n_fail++;
      $display("FAIL ripple_early: got CO=%b S=%h, want CO=0 S=0000", CO, S);
    end
    tick(1);
    n_tests++;
    if ({CO, S} !== 17'h1_0000) begin
      n_fail++;
      $display("FAIL ripple_ffff_0_1: got CO=%b S=%h, want CO=1 S=0000", CO, S);
    end
    drive(16'hFFFF, 16'hFFFF, 1'b1);
    tick(L);
    n_tests++;
    if ({CO, S} !== 17'h1_FFFF) begin
      n_fail++;
      $display("FAIL ripple_ffff_ffff_1: got CO=%b S=%h, want CO=1 S=ffff", CO, S);
    end
  endtask

  task automatic test_chunk_boundary();
    drive(16'h000F, 16'h0001, 1'b0);
    tick(L);
    n_tests++;
    if ({CO, S} !== 17'h0_0010) begin
      n_fail++;
      $display("FAIL chunk_000f_0001: got CO=%b S=%h, want CO=0 S=0010", CO, S);
    end
    drive(16'h0FFF, 16'h0001, 1'b0);
    tick(L);
    n_tests++;
    if ({CO, S} !== 17'h0_1000) begin
      n_fail++;
      $display("FAIL chunk_0fff_0001: got CO=%b S=%h, want CO=0 S=1000", CO, S);
    end
    drive(16'h00F0, 16'h0000, 1'b1);
    tick(L);
    n_tests++;
    if ({CO, S} !== 17'h0_00F1) begin
      n_fail++;
      $display("FAIL chunk_00f0_ci: got CO=%b S=%h, want CO=0 S=00f1", CO, S);
    end
    drive(16'h8000, 16'h8000, 1'b0);
    tick(L);
    n_tests++;
    if ({CO, S} !== 17'h1_0000) begin
      n_fail++;
      $display("FAIL chunk_msb_carry: got CO=%b S=%h, want CO=1 S=0000", CO, S);
    end
  endtask

  task automatic test_streaming();
    logic [N:0] q[$];
    logic [N:0] exp;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic ci;
    for (int i = 0; i < 1000; i++) begin
      a  = N'($urandom);
      b  = N'($urandom);
      ci = 1'($urandom);
      drive(a, b, ci);
      q.push_back({1'b0, a} + {1'b0, b} + {{N{1'b0}}, ci});
      tick(1);
      if (q.size() > STAGES) begin
        exp = q.pop_front();
        n_tests++;
        if ({CO, S} !== exp) begin
          n_fail++;
          $display("FAIL stream cycle %0d: got %h, want %h", i, {CO, S}, exp);
        end
      end
    end
    drive('0, '0, 1'b0);
    while (q.size() > 0) begin
      tick(1);
      exp = q.pop_front();
      n_tests++;
      if ({CO, S} !== exp) begin
        n_fail++;
        $display("FAIL stream_drain: got %h, want %h", {CO, S}, exp);
      end
    end
  endtask

  task automatic test_reset_midstream();
    drive(16'h1234, 16'h4321, 1'b0);
    tick(L + 2);
    n_tests++;
    if ({CO, S} !== 17'h0_5555) begin
      n_fail++;
      $display("FAIL midstream_pre: got CO=%b S=%h, want CO=0 S=5555", CO, S);
    end
    Reset_n = 1'b0;
    tick(1);
    n_tests++;
    if ({CO, S} !== 17'h0_0000) begin
      n_fail++;
      $display("FAIL midstream_reset: got CO=%b S=%h, want CO=0 S=0000", CO, S);
    end
    Reset_n = 1'b1;
    drive(16'h0001, 16'h0002, 1'b0);
    for (int k = 1; k <= L - 1; k++) begin
      tick(1);
      n_tests++;
      if ({CO, S} !== 17'h0_0000) begin
        n_fail++;
        $display("FAIL midstream_flush edge %0d: got CO=%b S=%h, want CO=0 S=0000",
                 k, CO, S);
      end
    end
    tick(1);
    n_tests++;
    if ({CO, S} !== 17'h0_0003) begin
      n_fail++;
      $display("FAIL midstream_resume: got CO=%b S=%h, want CO=0 S=0003", CO, S);
    end
  endtask

  task automatic test_latency();
    drive('0, '0, 1'b0);
    tick(L);
    drive(16'h0001, 16'h0001, 1'b0);
    // Capture edge t is the first tick; result must appear exactly at t+STAGES.
    for (int k = 0; k < STAGES; k++) begin
      tick(1);
      n_tests++;
      if (S !== 16'h0000) begin
        n_fail++;
        $display("FAIL latency_early edge t+%0d: got S=%h, want S=0000", k, S);
      end
    end
    tick(1);
    n_tests++;
    if ({CO, S} !== 17'h0_0002) begin
      n_fail++;
      $display("FAIL latency_valid: got CO=%b S=%h, want CO=0 S=0002", CO, S);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    Reset_n = 1'b0;
    drive('0, '0, 1'b0);
    #1;
    test_reset();
    test_low_range();
    test_ripple();
    test_chunk_boundary();
    test_streaming();
    test_reset_midstream();
    test_latency();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
